mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported 16-bit memory between the CPU instruction-fetch port (pc_*) and the load/store port (ldst_*).
- Sits between the pipelined cpu and the memory.
- Gives fixed priority to load/store, with a fairness limit so fetch cannot starve.
- Returns read data to the correct requester using a fixed-latency tag pipeline.

Parameters:
- RD_LATENCY, 1: memory read latency in cycles from accepted read to i_mem_rddata valid (1..4).
- MAX_LDST_STREAK, 3: consecutive ldst grants allowed while fetch is pending before fetch is forced (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_pc_rd  in  1  fetch read request; held until o_pc_wait=0.
- i_pc_addr  in  16  fetch address.
- o_pc_wait  out  1  fetch request not accepted this cycle.
- o_pc_rddata  out  16  fetch read data.
- o_pc_valid  out  1  one-cycle pulse, o_pc_rddata valid.
- i_ldst_rd  in  1  load request; held until o_ldst_wait=0.
- i_ldst_wr  in  1  store request; held until o_ldst_wait=0.
- i_ldst_addr  in  16  load/store address.
- i_ldst_wrdata  in  16  store data.
- o_ldst_wait  out  1  ldst request not accepted this cycle.
- o_ldst_rddata  out  16  load data.
- o_ldst_valid  out  1  one-cycle pulse, o_ldst_rddata valid.
- o_mem_addr  out  16  memory address.
- o_mem_rd  out  1  memory read strobe.
- o_mem_wr  out  1  memory write strobe.
- o_mem_wrdata  out  16  memory write data.
- i_mem_waitrequest  in  1  memory stall; the command is held and re-presented.
- i_mem_rddata  in  16  memory read data, valid RD_LATENCY cycles after acceptance.
- o_err  out  1  sticky: i_ldst_rd and i_ldst_wr were asserted together.

Behaviour:
- Reset (reset_n=0, async): FSM=PRIO_LDST, streak=0, tag pipeline cleared, o_err=0.
  - While in reset: o_mem_rd=o_mem_wr=0, o_pc_valid=o_ldst_valid=0, o_pc_wait=o_ldst_wait=1.
- Request decode: ldst_req = i_ldst_rd | i_ldst_wr. If both rd and wr are set, the command is treated as a write and o_err is set on the next edge.
- FSM, 2 states:
  - PRIO_LDST: grant ldst if ldst_req, else grant pc if i_pc_rd.
  - PRIO_PC: grant pc if i_pc_rd, else ldst.
  - PRIO_LDST -> PRIO_PC when an ldst grant is accepted with i_pc_rd=1 and streak+1 == MAX_LDST_STREAK.
  - PRIO_PC -> PRIO_LDST after a pc grant is accepted, or when i_pc_rd=0.
- streak counter (4b):
  - +1 on each accepted ldst grant while i_pc_rd=1.
  - Cleared on an accepted pc grant, or on any cycle with i_pc_rd=0.
  - Saturates; never wraps.
- Grant and memory command are combinational from the current state and requests (zero-cycle issue).
  - o_mem_* are driven from the granted requester's signals.
  - o_mem_wrdata = i_ldst_wrdata when ldst is granted, else 0.
- Accepted = granted & !i_mem_waitrequest.
  - Granted requester: wait = i_mem_waitrequest.
  - Non-granted active requester: wait = 1.
  - Idle requester: wait = 0.
- While i_mem_waitrequest=1, grant is frozen: no FSM or streak update, and the same command is presented next cycle even if the other requester arrives.
- Tag pipeline: RD_LATENCY entries of {valid, owner}.
  - Shifts every cycle.
  - Entry 0 is loaded on an accepted read with owner = granted requester; accepted writes load an invalid entry.
  - On the last stage: owner=pc gives o_pc_valid=1, owner=ldst gives o_ldst_valid=1.
  - Both rddata outputs = i_mem_rddata (combinational).
- Throughput: one accepted command per cycle, with back-to-back mixed owners. Return order equals issue order.
- Simultaneous pc and ldst requests on the cycle a response returns: issue and return are independent, no stall.
- Reset mid-operation clears in-flight tags. Responses for reads issued before reset are dropped (no valid pulse).

Decomposition:
- Package mem_arb_pkg:
  - typedef enum {PRIO_LDST, PRIO_PC} arb_state_t.
  - typedef enum logic {OWN_PC=0, OWN_LDST=1} owner_t.
  - typedef struct {logic valid; owner_t owner;} rd_tag_t.
- Sub-module rd_tag_pipe:
  - Parameterised by RD_LATENCY.
  - Holds the shift register of rd_tag_t.
  - Outputs the last-stage tag.

Test Plan:
- Single fetch: i_pc_rd=1, addr 0x0010, mem returns 0xA5A5 -> o_mem_rd=1 and addr=0x0010 in the same cycle; o_pc_valid pulses once RD_LATENCY cycles later with 0xA5A5; o_ldst_valid stays 0.
- Contention: pc and ldst read requested on the same cycle (0x0020 / 0x8000) -> ldst is issued first, o_pc_wait=1; pc is issued next cycle; responses return in order ldst then pc.
- Fairness: i_pc_rd held and ldst reads continuous, MAX_LDST_STREAK=3 -> issue sequence L,L,L,P,L,L,L,P.
- Waitrequest: store 0x1234 to 0x4000 with i_mem_waitrequest=1 for 2 cycles -> o_mem_wr/addr/wrdata stable for 3 cycles; o_ldst_wait=1,1,0; a pc request arriving mid-stall is not granted until after.
- Error: i_ldst_rd=i_ldst_wr=1 -> write issued, o_err=1 next cycle and sticky until reset_n=0.
- Reset mid-flight: pc read accepted, reset_n pulsed low before data returns -> no o_pc_valid; all outputs at reset values during reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    PRIO_LDST = 1'b0,
    PRIO_PC   = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_PC   = 1'b0,
    OWN_LDST = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  localparam rd_tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_PC};

  // Tag recorded for an accepted command; writes never produce a response.
  function automatic rd_tag_t make_tag(input logic accepted, input logic is_read,
                                       input owner_t owner);
    rd_tag_t t;
    t.valid = accepted & is_read;
    t.owner = owner;
    return t;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// CPU-side and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if;
  logic        i_pc_rd;
  logic [15:0] i_pc_addr;
  logic        o_pc_wait;
  logic [15:0] o_pc_rddata;
  logic        o_pc_valid;

  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [15:0] i_ldst_addr;
  logic [15:0] i_ldst_wrdata;
  logic        o_ldst_wait;
  logic [15:0] o_ldst_rddata;
  logic        o_ldst_valid;

  logic [15:0] o_mem_addr;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [15:0] o_mem_wrdata;
  logic        i_mem_waitrequest;
  logic [15:0] i_mem_rddata;

  logic        o_err;

  modport slave (
    input  i_pc_rd, i_pc_addr, i_ldst_rd, i_ldst_wr, i_ldst_addr, i_ldst_wrdata,
    input  i_mem_waitrequest, i_mem_rddata,
    output o_pc_wait, o_pc_rddata, o_pc_valid,
    output o_ldst_wait, o_ldst_rddata, o_ldst_valid,
    output o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata, o_err
  );

  modport master (
    output i_pc_rd, i_pc_addr, i_ldst_rd, i_ldst_wr, i_ldst_addr, i_ldst_wrdata,
    output i_mem_waitrequest, i_mem_rddata,
    input  o_pc_wait, o_pc_rddata, o_pc_valid,
    input  o_ldst_wait, o_ldst_rddata, o_ldst_valid,
    input  o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata, o_err
  );
endinterface

// File: rtl/rd_tag_pipe.sv
// Fixed-latency shift register of read tags; the last stage marks who owns
// the read data currently on the memory bus.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_r [RD_LATENCY];

  // Shift every cycle; reset discards all in-flight tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        stage_r[i] <= TAG_NONE;
      end
    end else begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign tag_out = stage_r[RD_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// load/store first with a streak limit so fetch cannot starve.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LATENCY      = 1,
  parameter int MAX_LDST_STREAK = 3
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [4:0] MAX_STREAK_W = 5'(MAX_LDST_STREAK);

  arb_state_t state_r, state_s;
  logic [3:0] streak_r, streak_s;
  logic       stall_r;
  owner_t     held_owner_r;
  logic       err_r;

  logic    ldst_req_s;
  logic    grant_pc_s;
  logic    grant_ldst_s;
  logic    granted_s;
  logic    accept_s;
  logic    is_read_s;
  owner_t  grant_owner_s;
  rd_tag_t tag_in_s;
  rd_tag_t tag_out_s;

  assign ldst_req_s = bus.i_ldst_rd | bus.i_ldst_wr;

  // Grant selection; a stalled command keeps its owner until the memory takes it.
  always_comb begin
    grant_pc_s   = 1'b0;
    grant_ldst_s = 1'b0;
    if (reset_n) begin
      if (stall_r) begin
        grant_ldst_s = (held_owner_r == OWN_LDST) & ldst_req_s;
        grant_pc_s   = (held_owner_r == OWN_PC) & bus.i_pc_rd;
      end else begin
        case (state_r)
          PRIO_LDST: begin
            grant_ldst_s = ldst_req_s;
            grant_pc_s   = bus.i_pc_rd & ~ldst_req_s;
          end
          PRIO_PC: begin
            grant_pc_s   = bus.i_pc_rd;
            grant_ldst_s = ldst_req_s & ~bus.i_pc_rd;
          end
          default: begin
            grant_pc_s   = 1'b0;
            grant_ldst_s = 1'b0;
          end
        endcase
      end
    end else begin
      grant_pc_s   = 1'b0;
      grant_ldst_s = 1'b0;
    end
  end

  assign granted_s     = grant_pc_s | grant_ldst_s;
  assign accept_s      = granted_s & ~bus.i_mem_waitrequest;
  assign grant_owner_s = grant_ldst_s ? OWN_LDST : OWN_PC;
  // rd+wr together is executed as a write.
  assign is_read_s     = grant_pc_s | (grant_ldst_s & ~bus.i_ldst_wr);
  assign tag_in_s      = make_tag(accept_s, is_read_s, grant_owner_s);

  // Memory command driven straight from the granted requester.
  always_comb begin
    bus.o_mem_addr   = 16'h0000;
    bus.o_mem_wrdata = 16'h0000;
    if (grant_ldst_s) begin
      bus.o_mem_addr   = bus.i_ldst_addr;
      bus.o_mem_wrdata = bus.i_ldst_wrdata;
    end else if (grant_pc_s) begin
      bus.o_mem_addr   = bus.i_pc_addr;
    end else begin
      bus.o_mem_addr   = 16'h0000;
    end
  end

  assign bus.o_mem_rd    = is_read_s;
  assign bus.o_mem_wr    = grant_ldst_s & bus.i_ldst_wr;
  assign bus.o_pc_wait   = ~reset_n | (grant_pc_s ? bus.i_mem_waitrequest : bus.i_pc_rd);
  assign bus.o_ldst_wait = ~reset_n | (grant_ldst_s ? bus.i_mem_waitrequest : ldst_req_s);

  // Priority FSM and streak counter; both freeze while the memory stalls.
  always_comb begin
    state_s  = state_r;
    streak_s = streak_r;
    if (bus.i_mem_waitrequest) begin
      state_s  = state_r;
      streak_s = streak_r;
    end else begin
      case (state_r)
        PRIO_LDST: begin
          if (accept_s && grant_ldst_s && bus.i_pc_rd &&
              (({1'b0, streak_r} + 5'd1) == MAX_STREAK_W)) begin
            state_s = PRIO_PC;
          end else begin
            state_s = PRIO_LDST;
          end
        end
        PRIO_PC: begin
          if ((accept_s && grant_pc_s) || !bus.i_pc_rd) begin
            state_s = PRIO_LDST;
          end else begin
            state_s = PRIO_PC;
          end
        end
        default: state_s = PRIO_LDST;
      endcase

      if (!bus.i_pc_rd || (accept_s && grant_pc_s)) begin
        streak_s = 4'd0;
      end else if (accept_s && grant_ldst_s && (streak_r != 4'hF)) begin
        streak_s = streak_r + 4'd1;
      end else begin
        streak_s = streak_r;
      end
    end
  end

  // Arbiter state, stall bookkeeping and the sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= PRIO_LDST;
      streak_r     <= 4'd0;
      stall_r      <= 1'b0;
      held_owner_r <= OWN_PC;
      err_r        <= 1'b0;
    end else begin
      state_r  <= state_s;
      streak_r <= streak_s;
      stall_r  <= granted_s & bus.i_mem_waitrequest;
      if (granted_s && bus.i_mem_waitrequest) begin
        held_owner_r <= grant_owner_s;
      end else begin
        held_owner_r <= held_owner_r;
      end
      err_r <= err_r | (bus.i_ldst_rd & bus.i_ldst_wr);
    end
  end

  rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk    (clk),
    .reset_n(reset_n),
    .tag_in (tag_in_s),
    .tag_out(tag_out_s)
  );

  assign bus.o_pc_valid    = tag_out_s.valid & (tag_out_s.owner == OWN_PC);
  assign bus.o_ldst_valid  = tag_out_s.valid & (tag_out_s.owner == OWN_LDST);
  assign bus.o_pc_rddata   = bus.i_mem_rddata;
  assign bus.o_ldst_rddata = bus.i_mem_rddata;
  assign bus.o_err         = err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-1 memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  mem_port_arbiter_if mif ();

  mem_port_arbiter #(
    .RD_LATENCY     (1),
    .MAX_LDST_STREAK(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (mif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_reqs();
    mif.i_pc_rd       = 1'b0;
    mif.i_pc_addr     = 16'h0000;
    mif.i_ldst_rd     = 1'b0;
    mif.i_ldst_wr     = 1'b0;
    mif.i_ldst_addr   = 16'h0000;
    mif.i_ldst_wrdata = 16'h0000;
    mif.i_mem_waitrequest = 1'b0;
  endtask

  // Memory: data returns one cycle after an accepted read; unwritten cells read addr^0x5A5A.
  logic [15:0] mem_q [logic [15:0]];
  logic        rd_go, wr_go;
  logic [15:0] m_addr, m_data;
  always begin
    @(negedge clk);
    #4;
    rd_go  = mif.o_mem_rd & ~mif.i_mem_waitrequest;
    wr_go  = mif.o_mem_wr & ~mif.i_mem_waitrequest;
    m_addr = mif.o_mem_addr;
    m_data = mif.o_mem_wrdata;
    @(posedge clk);
    if (wr_go) mem_q[m_addr] = m_data;
    if (rd_go) mif.i_mem_rddata = mem_q.exists(m_addr) ? mem_q[m_addr] : (m_addr ^ 16'h5A5A);
  end

  initial begin
    logic [15:0] exp_addr;
    mem_q[16'h0010] = 16'hA5A5;
    mif.i_mem_rddata = 16'h0000;
    clear_reqs();
    reset_n = 1'b0;
    mif.i_pc_rd   = 1'b1;
    mif.i_ldst_rd = 1'b1;
    #1;
    check_eq("rst_mem_rd",     16'(mif.o_mem_rd),     16'd0);
    check_eq("rst_mem_wr",     16'(mif.o_mem_wr),     16'd0);
    check_eq("rst_pc_wait",    16'(mif.o_pc_wait),    16'd1);
    check_eq("rst_ldst_wait",  16'(mif.o_ldst_wait),  16'd1);
    check_eq("rst_pc_valid",   16'(mif.o_pc_valid),   16'd0);
    check_eq("rst_ldst_valid", 16'(mif.o_ldst_valid), 16'd0);
    check_eq("rst_err",        16'(mif.o_err),        16'd0);
    @(negedge clk); clear_reqs();
    @(negedge clk); reset_n = 1'b1;

    // Single fetch
    @(negedge clk);
    mif.i_pc_rd = 1'b1; mif.i_pc_addr = 16'h0010;
    #1;
    check_eq("f1_mem_rd",   16'(mif.o_mem_rd),  16'd1);
    check_eq("f1_mem_addr", mif.o_mem_addr,     16'h0010);
    check_eq("f1_pc_wait",  16'(mif.o_pc_wait), 16'd0);
    @(negedge clk); mif.i_pc_rd = 1'b0;
    #1;
    check_eq("f1_pc_valid",   16'(mif.o_pc_valid),   16'd1);
    check_eq("f1_pc_rddata",  mif.o_pc_rddata,       16'hA5A5);
    check_eq("f1_ldst_valid", 16'(mif.o_ldst_valid), 16'd0);
    @(negedge clk); #1;
    check_eq("f1_pc_valid_end", 16'(mif.o_pc_valid), 16'd0);

    // Contention: ldst first, pc next, responses in issue order
    @(negedge clk);
    mif.i_pc_rd = 1'b1;   mif.i_pc_addr = 16'h0020;
    mif.i_ldst_rd = 1'b1; mif.i_ldst_addr = 16'h8000;
    #1;
    check_eq("c_addr0",    mif.o_mem_addr,       16'h8000);
    check_eq("c_pc_wait",  16'(mif.o_pc_wait),   16'd1);
    check_eq("c_ld_wait",  16'(mif.o_ldst_wait), 16'd0);
    @(negedge clk); mif.i_ldst_rd = 1'b0;
    #1;
    check_eq("c_addr1",     mif.o_mem_addr,        16'h0020);
    check_eq("c_pc_wait1",  16'(mif.o_pc_wait),    16'd0);
    check_eq("c_ld_valid",  16'(mif.o_ldst_valid), 16'd1);
    check_eq("c_ld_rddata", mif.o_ldst_rddata,     16'hDA5A);
    @(negedge clk); mif.i_pc_rd = 1'b0;
    #1;
    check_eq("c_pc_valid",  16'(mif.o_pc_valid),   16'd1);
    check_eq("c_pc_rddata", mif.o_pc_rddata,       16'h5A7A);
    check_eq("c_ld_valid2", 16'(mif.o_ldst_valid), 16'd0);

    // Fairness: L,L,L,P,L,L,L,P
    @(negedge clk);
    mif.i_pc_rd = 1'b1;   mif.i_pc_addr = 16'h0100;
    mif.i_ldst_rd = 1'b1; mif.i_ldst_addr = 16'h0200;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      #1;
      exp_addr = ((i % 4) == 3) ? 16'h0100 : 16'h0200;
      check_eq($sformatf("fair_%0d", i), mif.o_mem_addr, exp_addr);
    end
    @(negedge clk); clear_reqs();
    @(negedge clk);

    // Waitrequest: store held for 3 cycles, pc arriving mid-stall waits
    mif.i_ldst_wr = 1'b1; mif.i_ldst_addr = 16'h4000; mif.i_ldst_wrdata = 16'h1234;
    mif.i_mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin mif.i_pc_rd = 1'b1; mif.i_pc_addr = 16'h0300; end
      if (i == 2) mif.i_mem_waitrequest = 1'b0;
      #1;
      check_eq($sformatf("w_mem_wr_%0d", i), 16'(mif.o_mem_wr), 16'd1);
      check_eq($sformatf("w_addr_%0d", i),   mif.o_mem_addr,     16'h4000);
      check_eq($sformatf("w_data_%0d", i),   mif.o_mem_wrdata,   16'h1234);
      check_eq($sformatf("w_ldwait_%0d", i), 16'(mif.o_ldst_wait), (i == 2) ? 16'd0 : 16'd1);
      if (i != 0) check_eq($sformatf("w_pcwait_%0d", i), 16'(mif.o_pc_wait), 16'd1);
      @(negedge clk);
    end
    mif.i_ldst_wr = 1'b0;
    #1;
    check_eq("w_pc_addr", mif.o_mem_addr,     16'h0300);
    check_eq("w_pc_wait", 16'(mif.o_pc_wait), 16'd0);
    @(negedge clk); clear_reqs();
    mif.i_ldst_rd = 1'b1; mif.i_ldst_addr = 16'h4000;
    @(negedge clk); clear_reqs();
    #1;
    check_eq("w_readback_valid", 16'(mif.o_ldst_valid), 16'd1);
    check_eq("w_readback_data",  mif.o_ldst_rddata,     16'h1234);

    // Error: rd+wr together executes a write and sets the sticky flag
    @(negedge clk);
    mif.i_ldst_rd = 1'b1; mif.i_ldst_wr = 1'b1;
    mif.i_ldst_addr = 16'h5000; mif.i_ldst_wrdata = 16'hBEEF;
    #1;
    check_eq("e_mem_wr", 16'(mif.o_mem_wr), 16'd1);
    check_eq("e_mem_rd", 16'(mif.o_mem_rd), 16'd0);
    check_eq("e_err0",   16'(mif.o_err),    16'd0);
    @(negedge clk); clear_reqs();
    #1;
    check_eq("e_err1",     16'(mif.o_err),        16'd1);
    check_eq("e_ld_valid", 16'(mif.o_ldst_valid), 16'd0);
    @(negedge clk); #1;
    check_eq("e_err_sticky", 16'(mif.o_err), 16'd1);

    // Reset mid-flight: accepted fetch never reports valid
    @(negedge clk);
    mif.i_pc_rd = 1'b1; mif.i_pc_addr = 16'h0010;
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check_eq("r_pc_valid",  16'(mif.o_pc_valid),  16'd0);
    check_eq("r_mem_rd",    16'(mif.o_mem_rd),    16'd0);
    check_eq("r_pc_wait",   16'(mif.o_pc_wait),   16'd1);
    check_eq("r_ldst_wait", 16'(mif.o_ldst_wait), 16'd1);
    check_eq("r_err",       16'(mif.o_err),       16'd0);
    @(negedge clk); clear_reqs();
    @(negedge clk); reset_n = 1'b1;
    #1;
    check_eq("r_pc_valid_post", 16'(mif.o_pc_valid), 16'd0);
    @(negedge clk); #1;
    check_eq("r_pc_valid_post2", 16'(mif.o_pc_valid), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
